// File: rtl/tanh4_share_ctrl.sv
// Round-robin controller time-sharing a single 4-bit approximate tanh core among NREQ requesters.
// One operand is granted, evaluated on the next cycle and presented on a backpressured output.
module tanh4_share_ctrl #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    output logic [3:0]        out_data,
    output logic [IDW-1:0]    out_id,
    input  logic              out_ready,
    output logic              busy,
    output logic [15:0]       done_cnt
);

    typedef enum logic [1:0] {StIdle, StBusy, StOut} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [3:0]     opnd_q, opnd_d;
    logic [3:0]     res_q, res_d;
    logic           out_valid_q, out_valid_d;
    logic [15:0]    cnt_q, cnt_d;

    logic              grant_en, grant_any, do_grant;
    logic [IDW-1:0]    grant_idx;
    logic [IDW:0]      cand;
    logic [2*NREQ-1:0] valid_rot;
    logic [3:0]        opnd_sel;
    logic [3:0]        core_y;

    // Rotate so bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        valid_rot = {req_valid, req_valid} >> ptr_q;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (valid_rot[k] && !grant_any) begin
                grant_any = 1'b1;
                cand      = {1'b0, ptr_q} + (IDW+1)'(k);
                if (cand >= (IDW+1)'(NREQ)) begin
                    cand = cand - (IDW+1)'(NREQ);
                end
                grant_idx = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        opnd_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                opnd_sel = req_data[4*i +: 4];
            end
        end
    end

    assign grant_en  = !rst && ((state_q == StIdle) || (state_q == StOut && out_ready));
    assign do_grant  = grant_en && grant_any;
    assign req_ready = do_grant ? (NREQ'(1) << grant_idx) : '0;

    // The one shared tanh core, fed only from the operand register.
    assign core_y = {opnd_q[1],
                     opnd_q[1] | (opnd_q[3] & opnd_q[2] & ~opnd_q[0]),
                     opnd_q[0],
                     opnd_q[0]};

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        opnd_d      = opnd_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;

        case (state_q)
            StIdle: begin
                if (grant_any) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                res_d       = core_y;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    cnt_d       = cnt_q + 16'd1;
                    out_valid_d = 1'b0;
                    state_d     = grant_any ? StBusy : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (do_grant) begin
            opnd_d = opnd_sel;
            id_d   = grant_idx;
            ptr_d  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            id_q        <= '0;
            opnd_q      <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            opnd_q      <= opnd_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = res_q;
    assign out_id    = id_q;
    assign busy      = (state_q != StIdle);
    assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_tanh4_share_ctrl.sv
// Bench for tanh4_share_ctrl: core truth table, arbitration order, backpressure, reset, counter
// wrap, then random traffic against a transaction-level reference model.
module tb_tanh4_share_ctrl;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready;
    logic        busy;
    logic [15:0] done_cnt;

    tanh4_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    vec_t       vecs [16];
    logic [3:0] lut  [16];
    logic [3:0] ytab [16] = '{4'h0, 4'h3, 4'hC, 4'hF, 4'h0, 4'h3, 4'hC, 4'hF,
                              4'h0, 4'h3, 4'hC, 4'hF, 4'h4, 4'h3, 4'hC, 4'hF};
    logic [1:0] exp_ids [12] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1,
                                 2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic hard_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic logic [3:0] nib(input logic [15:0] d, input int idx);
        logic [15:0] s;
        s = d >> (4 * idx);
        return s[3:0];
    endfunction

    // Reference model state: an operand being evaluated, a result on display, the fairness
    // pointer, and the handshake count.
    int         m_ptr, m_id, m_cnt, g, idx, n, last;
    logic       m_inflight, m_show;
    logic [3:0] m_op, m_data, rv_sh, exp_rr, xi;

    initial begin
        for (int i = 0; i < 16; i++) begin
            xi          = 4'(i);
            vecs[xi].x  = xi;
            vecs[xi].y  = ytab[xi];
            lut[xi]     = ytab[xi];
        end

        // Reset asserted mid-transaction: outputs go to reset values without a clock edge.
        hard_reset();
        req_valid = 4'b0001;
        req_data  = 16'h0007;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_id", 32'(out_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done_cnt", 32'(done_cnt), 32'h0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'h0);
            chk("idle_out_valid", 32'(out_valid), 32'h0);
            @(posedge clk); #1;
        end

        // Exhaustive core table, requester 0 alone with immediate out_ready.
        for (int i = 0; i < 16; i++) begin
            xi        = 4'(i);
            req_valid = 4'b0001;
            req_data  = {12'h000, vecs[xi].x};
            out_ready = 1'b1;
            @(negedge clk);
            chk("core_req_ready", 32'(req_ready), 32'h1);
            chk("core_ov_t0", 32'(out_valid), 32'h0);
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            chk("core_ov_t1", 32'(out_valid), 32'h0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("core_ov_t2", 32'(out_valid), 32'h1);
            chk("core_data", 32'(out_data), 32'(vecs[xi].y));
            chk("core_id", 32'(out_id), 32'h0);
            @(posedge clk); #1;
        end
        chk("core_done_cnt", 32'(done_cnt), 32'd16);

        // Round-robin order with all requesters active, then with requester 1 withdrawn.
        hard_reset();
        req_valid = 4'b1111;
        req_data  = 16'hC6D1;
        out_ready = 1'b1;
        n    = 0;
        last = 0;
        for (int c = 0; c < 80 && n < 12; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                xi = 4'(n);
                chk("rr_id", 32'(out_id), 32'(exp_ids[xi]));
                chk("rr_data", 32'(out_data), 32'(lut[nib(req_data, int'(exp_ids[xi]))]));
                if (n > 0) chk("rr_spacing", 32'(c - last), 32'd2);
                last = c;
                n++;
            end
            @(posedge clk); #1;
            if (n == 8) req_valid = 4'b1101;
        end
        if (n < 12) chk("rr_timeout", 32'(n), 32'd12);

        // Backpressure: result 0x3 for requester 2 held while out_ready is low.
        hard_reset();
        req_valid = 4'b0100;
        req_data  = 16'h6D00;
        @(negedge clk);
        chk("bp_grant2", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        req_valid = 4'b1000;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_out_data", 32'(out_data), 32'h3);
            chk("bp_out_id", 32'(out_id), 32'h2);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_grant3", 32'(req_ready), 32'h8);
        @(posedge clk); #1;
        req_valid = '0;
        chk("bp_done_cnt", 32'(done_cnt), 32'd1);
        chk("bp_ov_drop", 32'(out_valid), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_next_valid", 32'(out_valid), 32'h1);
        chk("bp_next_data", 32'(out_data), 32'hC);
        chk("bp_next_id", 32'(out_id), 32'h3);

        // Reset while BUSY discards the result and forgets the pointer.
        hard_reset();
        req_valid = 4'b0010;
        req_data  = 16'h0020;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_grant1", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = '0;
        chk("mid_busy", 32'(busy), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_no_valid", 32'(out_valid), 32'h0);
            @(posedge clk); #1;
        end
        chk("mid_done_cnt", 32'(done_cnt), 32'h0);
        req_valid = 4'b1111;
        @(negedge clk);
        chk("mid_ptr0", 32'(req_ready), 32'h1);

        // Counter wrap from 0xFFFF.
        hard_reset();
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        req_valid = 4'b0001;
        req_data  = 16'h0001;
        out_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap_pre", 32'(done_cnt), 32'hFFFF);
        chk("wrap_ov", 32'(out_valid), 32'h1);
        @(posedge clk); #1;
        chk("wrap_post", 32'(done_cnt), 32'h0);

        // Random traffic against the reference model.
        hard_reset();
        m_ptr      = 0;
        m_id       = 0;
        m_cnt      = 0;
        m_inflight = 1'b0;
        m_show     = 1'b0;
        m_op       = '0;
        m_data     = '0;
        for (int c = 0; c < 1500; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_data  = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g = -1;
            if (!m_inflight && (!m_show || out_ready)) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx   = (m_ptr + k) % NREQ;
                    rv_sh = req_valid >> idx;
                    if (g < 0 && rv_sh[0]) g = idx;
                end
            end
            exp_rr = (g >= 0) ? (4'd1 << g) : 4'd0;
            chk("rand_req_ready", 32'(req_ready), 32'(exp_rr));
            chk("rand_out_valid", 32'(out_valid), 32'(m_show));
            chk("rand_busy", 32'(busy), 32'(m_inflight || m_show));
            chk("rand_done_cnt", 32'(done_cnt), 32'(m_cnt));
            if (m_show) begin
                chk("rand_out_data", 32'(out_data), 32'(m_data));
                chk("rand_out_id", 32'(out_id), 32'(m_id));
            end
            if (m_show && out_ready) begin
                m_cnt  = (m_cnt + 1) & 32'hFFFF;
                m_show = 1'b0;
            end
            if (m_inflight) begin
                m_show     = 1'b1;
                m_data     = lut[m_op];
                m_inflight = 1'b0;
            end
            if (g >= 0) begin
                m_inflight = 1'b1;
                m_op       = nib(req_data, g);
                m_id       = g;
                m_ptr      = (g + 1) % NREQ;
            end
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tanh4_share_ctrl.md
# tanh4_share_ctrl

Round-robin controller that time-shares one 4-bit approximate tanh core among up to eight requesters. Each requester offers a 4-bit operand over a valid/ready handshake. The controller grants one requester, registers its operand, evaluates the shared core, and presents the result with the requester ID on a single backpressured output port. It sits between the activation-function consumers of a layer and the single tanh instance, so the core is never duplicated per lane.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- IDW, 2, width of result ID; 2**IDW >= NREQ is required
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  bit i: requester i offers an operand
- req_data  in  4*NREQ  operand of requester i in bits [4i+3:4i]
- req_ready  out  NREQ  one-hot or zero; bit i high means requester i's operand transfers this cycle
- out_valid  out  1  result available
- out_data  out  4  tanh result
- out_id  out  IDW  index of the requester that owns out_data
- out_ready  in  1  consumer accepts the result
- busy  out  1  high in any state other than IDLE
- done_cnt  out  16  count of completed output handshakes; wraps

## Operation
- Core function, with operand x giving result y:
  - y[0] = x[0]
  - y[1] = x[0]
  - y[2] = x[1] | (x[3] & x[2] & ~x[0])
  - y[3] = x[1]
  - The core is instantiated exactly once and fed only from the operand register.
- FSM has three states: IDLE, BUSY, OUT.
  - IDLE: if any req_valid is set, grant per round-robin, then go to BUSY. Otherwise stay.
  - BUSY: result register <= f(operand register), out_valid <= 1, go to OUT.
  - OUT, out_ready=0: hold. No grant is issued and all outputs are stable.
  - OUT, out_ready=1, any req_valid: complete the current result and grant a new requester in the same cycle, then go to BUSY.
  - OUT, out_ready=1, no req_valid: go to IDLE, out_valid <= 0.
- Grant rules:
  - Grant is possible only in IDLE, or in OUT with out_ready=1.
  - Search req_valid starting at ptr, ascending with wrap. The first set bit g is granted.
  - req_ready[g] = 1 combinationally in that cycle, and only for g.
  - On the edge: operand register <= req_data[g], id register <= g, ptr <= (g+1) mod NREQ.
- req_ready depends combinationally on req_valid and state. It never depends on req_data.
- done_cnt increments on each out_valid & out_ready cycle. It wraps from 0xFFFF to 0x0000.
- Requesters may drop req_valid at any time without a transfer. There is no penalty and ptr is unchanged.

## Timing
- Reset values, applied asynchronously:
  - state = IDLE, ptr = 0
  - operand, result and id registers = 0
  - out_valid = 0, out_data = 0, out_id = 0
  - busy = 0, done_cnt = 0, req_ready = 0
- Latency: a transfer in cycle T gives out_valid = 1 in cycle T+2.
- Throughput:
  - With continuous requests and out_ready held at 1: one result every 2 cycles.
  - Single request from IDLE with immediate out_ready: 3 cycles per result, because OUT returns to IDLE.
- While out_valid=1 and out_ready=0: out_data, out_id and out_valid are held unchanged, and req_ready = 0.
- Simultaneous completion and new grant in OUT: the old result is consumed on that edge. out_valid drops for the BUSY cycle and reasserts the following cycle.
- Reset asserted in BUSY or OUT: the in-flight result is discarded, no handshake is counted, and the ptr history is lost.
- out_id for unused ID codes (index >= NREQ) never appears.

## Test plan
- Reset and idle:
  - Assert rst mid-sequence.
  - Check every output at its reset value immediately, before any clock edge.
  - After release with no valid: state stays IDLE, busy = 0.
- Exhaustive core check:
  - Requester 0 alone, out_ready=1, operands 0..15.
  - Each out_data matches the equations, e.g. 0xC -> 0x4, 0xD -> 0x3, 0x6 -> 0xC, 0xF -> 0xF.
  - out_valid rises exactly 2 cycles after the transfer.
- Round-robin fairness:
  - NREQ=4, all req_valid held high, out_ready=1.
  - out_id sequence is 0,1,2,3,0,... with one result every 2 cycles.
  - Drop req_valid[1]: sequence becomes 0,2,3,0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with result 0x3 / id 2 pending.
  - out_data and out_id stay stable, req_ready = 0.
  - Raise out_ready with req_valid[3] set: done_cnt +1, req_ready[3] = 1 in the same cycle.
- Reset mid-operation:
  - Assert rst during BUSY.
  - No out_valid appears, done_cnt = 0, and the next grant comes from ptr=0.
- Counter wrap:
  - Run 65536 handshakes, or force done_cnt to 0xFFFF and run one.
  - done_cnt reads 0x0000 afterwards.
